// File: rtl/ann_host_pkg.sv
// Shared constants, FSM state type and pointer helper for the ANN host-side responder.
package ann_host_pkg;
    localparam int DATA_W      = 156;
    localparam int INPUT_NUM   = 4;
    localparam int NEURON_NUM  = 8;
    localparam int N_WEIGHTS   = INPUT_NUM * NEURON_NUM + NEURON_NUM;
    localparam int PTR_W       = 6;
    localparam int TIMEOUT_DEF = 64;
    localparam int DIV_W       = 26;
    localparam int DIV_CONST   = 1000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SAVE    = 3'd1,
        ST_DUMP    = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_SCALE   = 3'd4,
        ST_RESPOND = 3'd5
    } state_e;

    function automatic logic [PTR_W-1:0] ptr_wrap_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(N_WEIGHTS - 1)) begin
            return '0;
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction
endpackage

// File: rtl/ann_div1000.sv
// Sequential restoring divider by DIV_CONST: one quotient bit per cycle, DIV_W cycles per divide.
module ann_div1000
    import ann_host_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [DIV_W-1:0] i_dividend,
    output logic             o_busy,
    output logic             o_done,
    output logic [DIV_W-1:0] o_quotient
);
    localparam int REM_W = 10;
    localparam logic [REM_W:0] DIVISOR = (REM_W + 1)'(DIV_CONST);

    logic [REM_W-1:0] r_rem;
    logic [DIV_W-1:0] r_quo;
    logic [4:0]       r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [REM_W:0]   w_shift;
    logic [REM_W:0]   w_diff;
    logic             w_ge;

    // Remainder never reaches the divisor, so the shifted value fits in REM_W+1 bits.
    assign w_shift = {r_rem, r_quo[DIV_W-1]};
    assign w_ge    = (w_shift >= DIVISOR);
    assign w_diff  = w_shift - DIVISOR;

    // Iteration state: load on start, shift/subtract while busy, pulse done on last bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_cnt  <= 5'd0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_rem  <= '0;
            r_quo  <= i_dividend;
            r_cnt  <= 5'(DIV_W);
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_rem  <= w_ge ? w_diff[REM_W-1:0] : w_shift[REM_W-1:0];
            r_quo  <= {r_quo[DIV_W-2:0], w_ge};
            r_cnt  <= r_cnt - 5'd1;
            r_busy <= (r_cnt != 5'd1);
            r_done <= (r_cnt == 5'd1);
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_quotient = r_quo;
endmodule

// File: rtl/ann_host_port.sv
// ANN host-side responder: weight bank save/dump, prediction launch and result return.
// Optional ANN_HOST_DIV1000_EN adds a SCALE state dividing the result by 1000.
module ann_host_port
    import ann_host_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                Clk,
    input  logic                Reset_h,
    input  logic [DATA_W-1:0]   Weight_in,
    input  logic                Weight_Save_enable,
    input  logic                Weight_Load_enable,
    input  logic [DATA_W-1:0]   Temperature_in_0,
    input  logic [DATA_W-1:0]   Temperature_in_1,
    input  logic [DATA_W-1:0]   Temperature_in_2,
    input  logic [DATA_W-1:0]   Temperature_in_3,
    input  logic                tb_rev_ready_h,
    output logic [DATA_W-1:0]   Data_out,
    output logic [DATA_W-1:0]   New_weight_out,
    output logic                Ready_Signal,
    output logic                Err,
    input  logic [PTR_W-1:0]    core_w_addr,
    output logic [DATA_W-1:0]   core_w_data,
    output logic [4*DATA_W-1:0] core_temp,
    output logic                core_start_h,
    input  logic                core_done_h,
    input  logic [DATA_W-1:0]   core_result
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_bank [N_WEIGHTS];
    logic [PTR_W-1:0]    r_wr_ptr, w_wr_ptr_nxt, r_rd_ptr, w_rd_ptr_nxt;
    logic                r_wvalid, w_wvalid_nxt, r_err, w_err_nxt;
    logic                r_ready, w_ready_nxt, r_start, w_start_nxt, r_rev_prev;
    logic [DATA_W-1:0]   r_dout, w_dout_nxt, r_nwo, w_nwo_nxt, r_result, w_result_nxt;
    logic [4*DATA_W-1:0] r_temp, w_temp_nxt;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic                w_bank_we, w_edge;

    assign w_edge = tb_rev_ready_h & ~r_rev_prev;

`ifdef ANN_HOST_DIV1000_EN
    logic              w_div_start, w_div_busy, w_div_done;
    logic [DIV_W-1:0]  w_quo;
    logic [DATA_W-1:0] w_div_result;

    assign w_div_start  = (r_state == ST_COMPUTE) && core_done_h;
    assign w_div_result = {{(DATA_W - DIV_W){1'b0}}, w_quo};

    ann_div1000 u_div (
        .i_clk      (Clk),
        .i_rst      (Reset_h),
        .i_start    (w_div_start),
        .i_dividend (core_result[DIV_W-1:0]),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quotient (w_quo)
    );
`endif

    // Next-state and datapath update for the host protocol FSM.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_wvalid_nxt = r_wvalid;
        w_err_nxt    = r_err;
        w_ready_nxt  = r_ready;
        w_start_nxt  = 1'b0;
        w_dout_nxt   = r_dout;
        w_nwo_nxt    = r_nwo;
        w_result_nxt = r_result;
        w_temp_nxt   = r_temp;
        w_cnt_nxt    = r_cnt;
        w_bank_we    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Weight_Save_enable) begin
                    w_bank_we    = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
                    w_ready_nxt  = 1'b0;
                    w_err_nxt    = r_err | Weight_Load_enable;
                    w_state_nxt  = ST_SAVE;
                end else if (Weight_Load_enable) begin
                    w_nwo_nxt    = r_bank[r_rd_ptr];
                    w_rd_ptr_nxt = ptr_wrap_inc(r_rd_ptr);
                    w_state_nxt  = ST_DUMP;
                end else if (w_edge && !r_wvalid) begin
                    w_err_nxt = 1'b1;
                end else if (w_edge) begin
                    w_temp_nxt  = {Temperature_in_3, Temperature_in_2, Temperature_in_1, Temperature_in_0};
                    w_ready_nxt = 1'b0;
                    w_start_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_COMPUTE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SAVE: begin
                if (Weight_Save_enable && (r_wr_ptr == PTR_W'(N_WEIGHTS))) begin
                    w_err_nxt = 1'b1;
                end else if (Weight_Save_enable) begin
                    w_bank_we    = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
                    w_err_nxt    = r_err | Weight_Load_enable;
                end else begin
                    w_wvalid_nxt = (r_wr_ptr == PTR_W'(N_WEIGHTS));
                    w_wr_ptr_nxt = '0;
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_DUMP: begin
                w_err_nxt = r_err | Weight_Save_enable;
                if (Weight_Load_enable) begin
                    w_nwo_nxt    = r_bank[r_rd_ptr];
                    w_rd_ptr_nxt = ptr_wrap_inc(r_rd_ptr);
                end else begin
                    w_rd_ptr_nxt = '0;
                    w_state_nxt  = ST_IDLE;
                end
            end
            ST_COMPUTE: begin
                w_err_nxt = r_err | Weight_Save_enable | Weight_Load_enable | w_edge;
                if (core_done_h) begin
                    w_result_nxt = core_result;
`ifdef ANN_HOST_DIV1000_EN
                    w_state_nxt  = ST_SCALE;
`else
                    w_state_nxt  = ST_RESPOND;
`endif
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_err_nxt    = 1'b1;
                    w_result_nxt = '0;
                    w_state_nxt  = ST_RESPOND;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
`ifdef ANN_HOST_DIV1000_EN
            ST_SCALE: begin
                w_err_nxt = r_err | Weight_Save_enable | Weight_Load_enable | w_edge;
                if (w_div_done && !w_div_busy) begin
                    w_result_nxt = w_div_result;
                    w_state_nxt  = ST_RESPOND;
                end else begin
                    w_state_nxt = ST_SCALE;
                end
            end
`endif
            ST_RESPOND: begin
                w_dout_nxt  = r_result;
                w_ready_nxt = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Control and output registers; reset aborts any transaction in flight.
    always_ff @(posedge Clk) begin
        if (Reset_h) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_wvalid   <= 1'b0;
            r_err      <= 1'b0;
            r_ready    <= 1'b0;
            r_start    <= 1'b0;
            r_rev_prev <= 1'b0;
            r_dout     <= '0;
            r_nwo      <= '0;
            r_result   <= '0;
            r_temp     <= '0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_wvalid   <= w_wvalid_nxt;
            r_err      <= w_err_nxt;
            r_ready    <= w_ready_nxt;
            r_start    <= w_start_nxt;
            r_rev_prev <= tb_rev_ready_h;
            r_dout     <= w_dout_nxt;
            r_nwo      <= w_nwo_nxt;
            r_result   <= w_result_nxt;
            r_temp     <= w_temp_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    // Weight bank storage; contents survive reset.
    always_ff @(posedge Clk) begin
        if (w_bank_we && !Reset_h) begin
            r_bank[r_wr_ptr] <= Weight_in;
        end
    end

    assign core_w_data    = (core_w_addr < PTR_W'(N_WEIGHTS)) ? r_bank[core_w_addr] : '0;
    assign Data_out       = r_dout;
    assign New_weight_out = r_nwo;
    assign Ready_Signal   = r_ready;
    assign Err            = r_err;
    assign core_temp      = r_temp;
    assign core_start_h   = r_start;
endmodule
